// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for the shared multiply-divide unit in EX.
// Optional feature: define MD_DIV0_FAST_EN to finish divides by zero after one busy cycle.
module md_issue_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic [3:0] ex_op,
  input  logic       ex_flush,
  input  logic       cancel,
  input  logic       div_b_zero,
  output logic       stall,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       md_stop,
  output logic       md_done,
  output logic       hilo_wr,
  output logic       hilo_sel,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic is_start, is_write, is_div, is_md, issue_ok, fast_div0;
  logic start_c, stop_c, done_c, wr_c, sel_c, stall_c;
  logic [1:0] op_c;

  always_comb begin
    is_start = (ex_op >= 4'd1) && (ex_op <= 4'd4);
    is_div   = (ex_op == 4'd3) || (ex_op == 4'd4);
    is_write = (ex_op == 4'd7) || (ex_op == 4'd8);
    is_md    = (ex_op >= 4'd1) && (ex_op <= 4'd8);
    issue_ok = ex_valid && !ex_flush;
  end

`ifdef MD_DIV0_FAST_EN
  assign fast_div0 = is_div && div_b_zero;
`else
  logic unused_div_b_zero;
  assign unused_div_b_zero = div_b_zero;
  assign fast_div0         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_c = 1'b0;
    op_c    = 2'd0;
    stop_c  = 1'b0;
    done_c  = 1'b0;
    wr_c    = 1'b0;
    sel_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Reads need nothing here: HI/LO are stable whenever the unit is idle.
        if (issue_ok && is_start) begin
          start_c = 1'b1;
          op_c    = 2'(ex_op - 4'd1);
          state_d = S_BUSY;
          if (fast_div0)   cnt_d = 32'd0;
          else if (is_div) cnt_d = 32'(DIV_CYC - 1);
          else             cnt_d = 32'(MULT_CYC - 1);
        end else if (issue_ok && is_write) begin
          wr_c  = 1'b1;
          sel_c = (ex_op == 4'd8);
        end
      end
      S_BUSY: begin
        // Cancel wins over completion so a killed op never writes HI/LO.
        if (cancel) begin
          stop_c  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else if (cnt_q == 32'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
    stall_c = ex_valid && is_md && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Combinational issue strobes are masked so nothing leaks out while reset is held.
  always_comb begin
    stall    = reset && stall_c;
    md_start = reset && start_c;
    md_op    = reset ? op_c : 2'd0;
    md_stop  = reset && stop_c;
    md_done  = reset && done_c;
    hilo_wr  = reset && wr_c;
    hilo_sel = reset && sel_c;
    busy     = reset && (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios plus random traffic
// compared every cycle against an issue-time based model.
module tb_md_issue_ctrl;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
`ifdef MD_DIV0_FAST_EN
  localparam int DIV0_DONE = 2;
`else
  localparam int DIV0_DONE = 11;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ex_valid = 1'b0;
  logic [3:0] ex_op = 4'd0;
  logic       ex_flush = 1'b0;
  logic       cancel = 1'b0;
  logic       div_b_zero = 1'b0;
  logic       stall, md_start, md_stop, md_done, hilo_wr, hilo_sel, busy;
  logic [1:0] md_op;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_flush(ex_flush), .cancel(cancel), .div_b_zero(div_b_zero),
    .stall(stall), .md_start(md_start), .md_op(md_op), .md_stop(md_stop),
    .md_done(md_done), .hilo_wr(hilo_wr), .hilo_sel(hilo_sel), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int now = 0;

  // Model: an operation is described only by when it issued and how long it takes.
  bit m_active = 1'b0;
  int m_issue = 0;
  int m_lat = 0;

  logic s_stall, s_start, s_stop, s_done, s_wr, s_sel, s_busy;
  logic [1:0] s_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  task automatic step(input logic rv, input logic v, input logic [3:0] op,
                      input logic fl, input logic cn, input logic bz);
    bit e_busy, e_done, e_stop, e_stall, e_start, e_wr, md_cls, st_cls, wr_cls;
    reset = rv; ex_valid = v; ex_op = op; ex_flush = fl; cancel = cn; div_b_zero = bz;
    @(negedge clk);
    s_stall = stall; s_start = md_start; s_op = md_op; s_stop = md_stop;
    s_done = md_done; s_wr = hilo_wr; s_sel = hilo_sel; s_busy = busy;
    md_cls = (op >= 1) && (op <= 8);
    st_cls = (op >= 1) && (op <= 4);
    wr_cls = (op == 7) || (op == 8);
    if (!rv) begin
      {e_busy, e_done, e_stop, e_stall, e_start, e_wr} = '0;
    end else begin
      e_busy  = m_active;
      e_done  = m_active && (now == m_issue + m_lat + 1);
      e_stop  = m_active && cn && (now <= m_issue + m_lat);
      e_stall = v && md_cls && m_active;
      e_start = !m_active && v && !fl && st_cls;
      e_wr    = !m_active && v && !fl && wr_cls;
    end
    chk("busy", 32'(s_busy), 32'(e_busy));
    chk("md_done", 32'(s_done), 32'(e_done));
    chk("md_stop", 32'(s_stop), 32'(e_stop));
    chk("stall", 32'(s_stall), 32'(e_stall));
    chk("md_start", 32'(s_start), 32'(e_start));
    chk("hilo_wr", 32'(s_wr), 32'(e_wr));
    if (e_start) chk("md_op", 32'(s_op), 32'(op) - 1);
    if (e_wr) chk("hilo_sel", 32'(s_sel), 32'(op == 4'd8));
    if (!rv || e_done || e_stop) begin
      m_active = 1'b0;
    end else if (e_start) begin
      m_active = 1'b1;
      m_issue  = now;
      m_lat    = (op >= 3) ? DIV_CYC : MULT_CYC;
`ifdef MD_DIV0_FAST_EN
      if (op >= 3 && bz) m_lat = 1;
`endif
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  initial begin
    // Reset state
    step(0, 1, 4'd1, 0, 0, 0);
    chk("rst_start", 32'(s_start), 0);
    chk("rst_busy", 32'(s_busy), 0);
    step(0, 0, 4'd0, 0, 0, 0);
    step(1, 0, 4'd0, 0, 0, 0);
    chk("post_rst_busy", 32'(s_busy), 0);

    // MULT followed by a dependent MFHI
    step(1, 1, 4'd1, 0, 0, 0);
    chk("mult_start", 32'(s_start), 1);
    chk("mult_op", 32'(s_op), 0);
    for (int c = 1; c <= 6; c++) begin
      step(1, 1, 4'd5, 0, 0, 0);
      chk("mfhi_stall", 32'(s_stall), 1);
      if (c == 6) chk("mult_done", 32'(s_done), 1);
    end
    step(1, 1, 4'd5, 0, 0, 0);
    chk("mfhi_release", 32'(s_stall), 0);

    // DIVU then DIV back-to-back
    step(1, 1, 4'd4, 0, 0, 0);
    chk("divu_op", 32'(s_op), 3);
    for (int c = 1; c <= 11; c++) begin
      step(1, 1, 4'd3, 0, 0, 0);
      chk("b2b_stall", 32'(s_stall), 1);
      if (c == 11) chk("divu_done", 32'(s_done), 1);
    end
    step(1, 1, 4'd3, 0, 0, 0);
    chk("div2_start", 32'(s_start), 1);
    chk("div2_op", 32'(s_op), 2);
    for (int c = 13; c <= 23; c++) begin
      step(1, 0, 4'd0, 0, 0, 0);
      if (c == 23) chk("div2_done", 32'(s_done), 1);
    end
    step(1, 0, 4'd0, 0, 0, 0);

    // DIV cancelled at cycle 4, then MTLO
    step(1, 1, 4'd3, 0, 0, 0);
    for (int c = 1; c <= 3; c++) step(1, 0, 4'd0, 0, 0, 0);
    step(1, 0, 4'd0, 0, 1, 0);
    chk("cancel_stop", 32'(s_stop), 1);
    step(1, 1, 4'd8, 0, 0, 0);
    chk("cancel_idle", 32'(s_busy), 0);
    chk("mtlo_wr", 32'(s_wr), 1);
    chk("mtlo_sel", 32'(s_sel), 1);
    for (int c = 6; c <= 14; c++) begin
      step(1, 0, 4'd0, 0, 0, 0);
      chk("cancel_no_done", 32'(s_done), 0);
    end

    // Cancel in the DONE cycle is ignored; flushed MULTU never starts
    step(1, 1, 4'd1, 0, 0, 0);
    for (int c = 1; c <= 5; c++) step(1, 0, 4'd0, 0, 0, 0);
    step(1, 0, 4'd0, 0, 1, 0);
    chk("done_vs_cancel", 32'(s_done), 1);
    chk("done_no_stop", 32'(s_stop), 0);
    step(1, 1, 4'd2, 1, 0, 0);
    chk("flush_no_start", 32'(s_start), 0);
    step(1, 0, 4'd0, 0, 0, 0);

    // Divide by zero
    step(1, 1, 4'd3, 0, 0, 1);
    for (int c = 1; c <= 11; c++) begin
      step(1, 0, 4'd0, 0, 0, 0);
      if (c == DIV0_DONE) chk("div0_done", 32'(s_done), 1);
    end
    step(1, 0, 4'd0, 0, 0, 0);

    // Reset mid-DIV with cnt=6
    step(1, 1, 4'd3, 0, 0, 0);
    for (int c = 1; c <= 3; c++) step(1, 0, 4'd0, 0, 0, 0);
    step(0, 1, 4'd5, 0, 1, 0);
    chk("rst_mid_stall", 32'(s_stall), 0);
    chk("rst_mid_busy", 32'(s_busy), 0);
    chk("rst_mid_stop", 32'(s_stop), 0);
    for (int c = 0; c < 12; c++) begin
      step(1, 0, 4'd0, 0, 0, 0);
      chk("rst_no_done", 32'(s_done), 0);
      chk("rst_idle", 32'(s_busy), 0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic rv, v, fl, cn, bz;
      logic [3:0] op;
      rv = ($urandom_range(0, 299) != 0);
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      fl = ($urandom_range(0, 9) == 0);
      cn = ($urandom_range(0, 19) == 0);
      bz = ($urandom_range(0, 2) == 0);
      step(rv, v, op, fl, cn, bz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
